dm_lsu: RTL and testbench

Load/store unit that acts as the initiator in front of the 4 KiB word-addressed data memory (`dm_4k`). It accepts word, halfword and byte load/store requests from the datapath over a req/done handshake. It performs sign or zero extension on loads and read-modify-write for sub-word stores, because the memory only writes whole words. Misaligned accesses are flagged and never reach the memory.

---
 rtl/dm_lsu_pkg.sv | 32 +++
 rtl/dm_lane_merge.sv | 48 ++++
 rtl/dm_lsu.sv | 134 +++++++++++++
 tb/tb_dm_lsu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit:
// access sizes, FSM states and the alignment rule.
package dm_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_MERGE,
        S_DONE,
        S_ERR
    } state_t;

    // Size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic r;
        r = 1'b0;
        unique case (1'b1)
            (size == SZ_BYTE): r = 1'b0;
            (size == SZ_HALF): r = off[0];
            default:           r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Little-endian lane extract/extend for loads and
// lane insert for sub-word stores.
module dm_lane_merge
    import dm_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_bsh;

    assign w_bsh  = {i_off, 3'b000};
    assign w_byte = i_word[w_bsh +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load = i_word;
        unique case (1'b1)
            (i_size == SZ_BYTE):
                o_load = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            (i_size == SZ_HALF):
                o_load = {{16{i_sign_ext & w_half[15]}}, w_half};
            default:
                o_load = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        unique case (1'b1)
            (i_size == SZ_BYTE):
                o_merged[w_bsh +: 8] = i_wdata[7:0];
            (i_size == SZ_HALF):
                if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
                else          o_merged[15:0]  = i_wdata[15:0];
            default:
                o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit in front of the word-addressed data memory;
// sub-word stores are done as read-modify-write.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int ADDR_HI = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               we,
    input  logic [1:0]         size,
    input  logic               sign_ext,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               done,
    output logic               busy,
    output logic               misalign,
    output logic [ADDR_HI-2:0] mem_addr,
    output logic [31:0]        mem_din,
    output logic               mem_we,
    input  logic [31:0]        mem_dout
);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_HI:0]   r_addr;
    logic [1:0]         r_size;
    logic               r_we;
    logic               r_sext;
    logic [31:0]        r_wdata;
    logic [31:0]        r_old;
    logic [31:0]        r_rdata;

    logic               w_is_word;
    logic               w_sub_store;
    logic [31:0]        w_word;
    logic [31:0]        w_load;
    logic [31:0]        w_merged;

    assign w_is_word   = r_size[1];
    assign w_sub_store = r_we & ~w_is_word;

    // MERGE works on the word captured in ACCESS, not live memory.
    assign w_word = (r_state == S_MERGE) ? r_old : mem_dout;

    dm_lane_merge u_merge (
        .i_word     (w_word),
        .i_off      (r_addr[1:0]),
        .i_size     (r_size),
        .i_sign_ext (r_sext),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_size  <= SZ_BYTE;
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_wdata <= '0;
            r_old   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && req) begin
                r_addr  <= addr[ADDR_HI:0];
                r_size  <= size;
                r_we    <= we;
                r_sext  <= sign_ext;
                r_wdata <= wdata;
            end
            if (r_state == S_ACCESS && !r_we) begin
                r_rdata <= w_load;
            end
            if (r_state == S_ACCESS && w_sub_store) begin
                r_old <= mem_dout;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next = is_misaligned(size, addr[1:0])
                           ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: w_next = w_sub_store ? S_MERGE : S_DONE;
            S_MERGE:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we  = 1'b0;
        mem_din = '0;
        unique case (1'b1)
            (r_state == S_ACCESS && r_we && w_is_word): begin
                mem_we  = 1'b1;
                mem_din = r_wdata;
            end
            (r_state == S_MERGE): begin
                mem_we  = 1'b1;
                mem_din = w_merged;
            end
            default: begin
                mem_we  = 1'b0;
                mem_din = '0;
            end
        endcase
    end

    assign mem_addr = r_addr[ADDR_HI:2];
    assign rdata    = r_rdata;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE) || (r_state == S_ERR);
    assign misalign = (r_state == S_ERR);

endmodule

// File: tb/tb_dm_lsu.sv
// Randomized bench for dm_lsu against a byte-array memory model
// plus directed cases for alignment, busy-ignore and reset.
module tb_dm_lsu;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        misalign;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    int n_tests;
    int n_fail;

    dm_lsu #(.ADDR_HI(11)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .done     (done),
        .busy     (busy),
        .misalign (misalign),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        clr;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr];

    logic [7:0]  rm [0:4095];
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {rm[4*idx+3], rm[4*idx+2], rm[4*idx+1], rm[4*idx]};
    endfunction

    function automatic logic [31:0] ref_load(input int a,
            input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = {24'h0, rm[a]};
            if (sx && v[7]) v[31:8] = '1;
        end else if (sz == 2'd1) begin
            v = {16'h0, rm[a+1], rm[a]};
            if (sx && v[15]) v[31:16] = '1;
        end else begin
            v = {rm[a+3], rm[a+2], rm[a+1], rm[a]};
        end
        return v;
    endfunction

    task automatic do_op(input logic iwe, input logic [1:0] isz,
            input logic isx, input logic [31:0] ia,
            input logic [31:0] iwd, input bit poke,
            output logic [31:0] ordata);
        int          a;
        int          nbytes;
        bit          mis;
        int          exp_lat;
        logic [7:0]  exp_mask;
        logic [7:0]  mask;
        int          lat;
        logic        got_mis;
        a      = int'(ia[11:0]);
        nbytes = (isz == 2'd0) ? 1 : (isz == 2'd1) ? 2 : 4;
        mis    = (a % nbytes) != 0;
        exp_mask = 8'h0;
        if (mis) exp_lat = 1;
        else if (iwe && nbytes < 4) exp_lat = 3;
        else exp_lat = 2;
        if (!mis && iwe) exp_mask = (nbytes < 4) ? 8'h04 : 8'h02;
        if (!mis && !iwe) exp_rdata = ref_load(a, isz, isx);
        if (!mis && iwe) begin
            for (int b = 0; b < nbytes; b++) rm[a+b] = iwd[8*b +: 8];
        end
        ordata = rdata;
        @(negedge clk);
        req = 1'b1; we = iwe; size = isz; sign_ext = isx;
        addr = ia; wdata = iwd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; mask = 8'h0; got_mis = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) mask[c] = 1'b1;
            if (done) begin
                lat = c; got_mis = misalign; ordata = rdata;
                break;
            end
            if (poke && c == 1) begin
                req = 1'b1; we = 1'b1; size = 2'd2;
                addr = 32'h80; wdata = 32'hDEADBEEF;
            end
            if (poke && c == 2) req = 1'b0;
        end
        chk("latency", lat, exp_lat);
        chk("misalign", {31'h0, got_mis}, {31'h0, mis});
        chk("rdata", ordata, exp_rdata);
        chk("mem_we_cycles", {24'h0, mask}, {24'h0, exp_mask});
        chk("mem_word", mem[a/4], ref_word(a/4));
        @(negedge clk);
        chk("idle_after", {30'h0, busy, done}, 32'h0);
    endtask

    logic [31:0] r;

    initial begin
        n_tests = 0; n_fail = 0;
        exp_rdata = '0;
        for (int i = 0; i < 4096; i++) rm[i] = 8'h0;
        rst_n = 1'b0; clr = 1'b1; req = 1'b0; we = 1'b0;
        size = 2'd0; sign_ext = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {rdata ^ mem_din, 22'h0, mem_addr},
            32'h0);
        chk("reset_ctl", {28'h0, done, busy, misalign, mem_we},
            32'h0);
        clr = 1'b0; rst_n = 1'b1;

        do_op(1, 2'd2, 0, 32'h000, 32'h00000001, 0, r);
        do_op(0, 2'd0, 1, 32'h000, 32'h0, 0, r);
        chk("lb_0", r, 32'h00000001);
        do_op(1, 2'd2, 0, 32'h010, 32'h80FF7F01, 0, r);
        do_op(0, 2'd0, 1, 32'h011, 32'h0, 0, r);
        chk("lb_11", r, 32'h0000007F);
        do_op(0, 2'd0, 0, 32'h012, 32'h0, 0, r);
        chk("lbu_12", r, 32'h000000FF);
        do_op(0, 2'd1, 1, 32'h012, 32'h0, 0, r);
        chk("lh_12", r, 32'hFFFF80FF);
        do_op(1, 2'd2, 0, 32'h020, 32'h00000001, 0, r);
        do_op(1, 2'd0, 0, 32'h023, 32'h000000AB, 0, r);
        chk("sb_word", mem[8], 32'hAB000001);
        do_op(0, 2'd2, 0, 32'h006, 32'h0, 0, r);
        chk("lw_mis_rdata", r, 32'hFFFF80FF);

        do_op(1, 2'd1, 0, 32'h042, 32'h00001234, 1, r);
        repeat (3) begin
            @(negedge clk);
            chk("no_queue", {30'h0, busy, done}, 32'h0);
        end
        chk("poke_word", mem[32], 32'h0);

        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0;
        addr = 32'h031; wdata = 32'h0000005A;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("merge_we", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_we", {30'h0, mem_we, busy}, 32'h0);
        exp_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_word", mem[12], ref_word(12));
        do_op(0, 2'd2, 0, 32'h010, 32'h0, 0, r);
        chk("after_rst", r, 32'h80FF7F01);

        for (int k = 0; k < 300; k++) begin
            do_op(1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)) | 32'($urandom & 32'hFFFFF000),
                  $urandom, 0, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
